// File: rtl/ubutterfly_stage.sv
// ubutterfly_stage
//   Parallel unary-bitstream radix-2 butterfly stage. NUM_BFLY bipolar butterflies
//   share one frame controller. Each butterfly has a loaded binary twiddle pair that
//   is turned into a thermometer bitstream against the frame counter. A frame lasts
//   L = 2^BITWIDTH input cycles, followed by a two-cycle drain and a one-cycle done.
//
//   Optional build macro: UBFLY_CONJ_EN adds iConj. It is sampled when a frame starts
//   and, when set, inverts the imaginary twiddle stream (inverse transform).
//
// Ports
//   iClk, iRst          clock, synchronous active-high reset
//   iEn                 low freezes every register
//   iStart / iAbort     start a frame (IDLE only) / return to IDLE
//   iWLoad, iWIdx       write twiddle pair iwReal/iwImg (codes 0..L) to butterfly iWIdx
//   iReal0..iImg1       per-butterfly input bits x0, x1
//   oInReady            inputs are being sampled this cycle
//   oValid, oDone       output bits valid / frame complete pulse
//   oReal0..oImg1       (x0 + x1*w)/2 and (x0 - x1*w)/2 bits
//
// state | meaning
// IDLE  | waiting for iStart, twiddle loads accepted
// RUN   | L cycles, inputs sampled, counter k = 0..L-1
// DRAIN | 2 cycles, pipeline empties
// DONE  | 1 cycle, oDone pulse
module ubutterfly_stage #(
    parameter int BITWIDTH = 4,
    parameter int NUM_BFLY = 2,
    localparam int IDXW = (NUM_BFLY > 1) ? $clog2(NUM_BFLY) : 1
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iEn,
    input  logic                iStart,
    input  logic                iAbort,
    input  logic                iWLoad,
    input  logic [IDXW-1:0]     iWIdx,
    input  logic [BITWIDTH:0]   iwReal,
    input  logic [BITWIDTH:0]   iwImg,
`ifdef UBFLY_CONJ_EN
    input  logic                iConj,
`endif
    input  logic [NUM_BFLY-1:0] iReal0,
    input  logic [NUM_BFLY-1:0] iImg0,
    input  logic [NUM_BFLY-1:0] iReal1,
    input  logic [NUM_BFLY-1:0] iImg1,
    output logic                oInReady,
    output logic                oValid,
    output logic                oDone,
    output logic [NUM_BFLY-1:0] oReal0,
    output logic [NUM_BFLY-1:0] oImg0,
    output logic [NUM_BFLY-1:0] oReal1,
    output logic [NUM_BFLY-1:0] oImg1
);

    localparam logic [BITWIDTH:0]   CODE_MAX = (BITWIDTH + 1)'(1 << BITWIDTH);
    localparam logic [BITWIDTH-1:0] K_LAST   = '1;
    localparam logic [BITWIDTH-1:0] K_ONE    = BITWIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t              state;
    logic [BITWIDTH-1:0] cnt;
    logic [BITWIDTH:0]   tw_real [NUM_BFLY];
    logic [BITWIDTH:0]   tw_img  [NUM_BFLY];
    logic                conj;
    logic                conj_in;

    logic                v1, v2, s2_sel;
    logic [NUM_BFLY-1:0] req_q, ieq_q, r0_q, i0_q;
    logic [NUM_BFLY-1:0] out_r0, out_i0, out_r1, out_i1;

    logic [BITWIDTH:0]   k_ext;
    logic [BITWIDTH:0]   ld_real, ld_img;
    logic [NUM_BFLY-1:0] wr, wi, req, ieq;

`ifdef UBFLY_CONJ_EN
    assign conj_in = iConj;
`else
    assign conj_in = 1'b0;
`endif

    // k zero-extended to the twiddle width; also guarantees a bit 1 exists for s2.
    assign k_ext   = {1'b0, cnt};
    assign ld_real = (iwReal > CODE_MAX) ? CODE_MAX : iwReal;
    assign ld_img  = (iwImg  > CODE_MAX) ? CODE_MAX : iwImg;

    // Bipolar multiply is XNOR; the k[0] select alternates real/imag product terms.
    always_comb begin
        wr  = '0;
        wi  = '0;
        req = '0;
        ieq = '0;
        for (int b = 0; b < NUM_BFLY; b++) begin
            wr[b]  = tw_real[b] > k_ext;
            wi[b]  = (tw_img[b] > k_ext) ^ conj;
            req[b] = cnt[0] ? ~(iReal1[b] ^ wr[b]) : (iImg1[b] ^ wi[b]);
            ieq[b] = cnt[0] ? ~(iReal1[b] ^ wi[b]) : ~(iImg1[b] ^ wr[b]);
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            conj   <= 1'b0;
            v1     <= 1'b0;
            v2     <= 1'b0;
            s2_sel <= 1'b0;
            req_q  <= '0;
            ieq_q  <= '0;
            r0_q   <= '0;
            i0_q   <= '0;
            out_r0 <= '0;
            out_i0 <= '0;
            out_r1 <= '0;
            out_i1 <= '0;
            for (int b = 0; b < NUM_BFLY; b++) begin
                tw_real[b] <= '0;
                tw_img[b]  <= '0;
            end
        end else if (iEn) begin
            if (iAbort) begin
                state  <= S_IDLE;
                cnt    <= '0;
                v1     <= 1'b0;
                v2     <= 1'b0;
                out_r0 <= '0;
                out_i0 <= '0;
                out_r1 <= '0;
                out_i1 <= '0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (iStart) begin
                            state <= S_RUN;
                            cnt   <= '0;
                            conj  <= conj_in;
                        end
                    end
                    S_RUN: begin
                        cnt <= cnt + K_ONE;
                        if (cnt == K_LAST) state <= S_DRAIN;
                    end
                    S_DRAIN: begin
                        if (cnt == K_ONE) begin
                            state <= S_DONE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + K_ONE;
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase

                v1     <= (state == S_RUN);
                v2     <= v1;
                req_q  <= req;
                ieq_q  <= ieq;
                r0_q   <= iReal0;
                i0_q   <= iImg0;
                s2_sel <= k_ext[1];

                // Output bits are forced to 0 outside the valid window.
                if (v1) begin
                    out_r0 <= s2_sel ? r0_q : req_q;
                    out_r1 <= s2_sel ? r0_q : ~req_q;
                    out_i0 <= s2_sel ? i0_q : ieq_q;
                    out_i1 <= s2_sel ? i0_q : ~ieq_q;
                end else begin
                    out_r0 <= '0;
                    out_i0 <= '0;
                    out_r1 <= '0;
                    out_i1 <= '0;
                end
            end

            // Out-of-range indices match no lane and are dropped.
            if (state == S_IDLE && iWLoad) begin
                for (int b = 0; b < NUM_BFLY; b++) begin
                    if (iWIdx == IDXW'(b)) begin
                        tw_real[b] <= ld_real;
                        tw_img[b]  <= ld_img;
                    end
                end
            end
        end
    end

    // A stalled cycle presents nothing: strobes and bits are masked by iEn so a
    // downstream consumer sees a gap rather than a repeated bit or a doubled pulse.
    assign oInReady = iEn & (state == S_RUN);
    assign oValid   = iEn & v2;
    assign oDone    = iEn & (state == S_DONE);
    assign oReal0   = out_r0 & {NUM_BFLY{iEn}};
    assign oImg0    = out_i0 & {NUM_BFLY{iEn}};
    assign oReal1   = out_r1 & {NUM_BFLY{iEn}};
    assign oImg1    = out_i1 & {NUM_BFLY{iEn}};

endmodule

// File: tb/tb_ubutterfly_stage.sv
module tb_ubutterfly_stage;

    localparam int BW = 4;
    localparam int NB = 2;
    localparam int L  = 16;
`ifdef UBFLY_CONJ_EN
    localparam bit CONJ_EN = 1'b1;
`else
    localparam bit CONJ_EN = 1'b0;
`endif

    logic          iClk = 1'b0;
    logic          iRst, iEn, iStart, iAbort, iWLoad;
    logic [0:0]    iWIdx;
    logic [BW:0]   iwReal, iwImg;
`ifdef UBFLY_CONJ_EN
    logic          iConj;
`endif
    logic [NB-1:0] iReal0, iImg0, iReal1, iImg1;
    logic          oInReady, oValid, oDone;
    logic [NB-1:0] oReal0, oImg0, oReal1, oImg1;

    ubutterfly_stage #(.BITWIDTH(BW), .NUM_BFLY(NB)) dut (
        .iClk(iClk), .iRst(iRst), .iEn(iEn), .iStart(iStart), .iAbort(iAbort),
        .iWLoad(iWLoad), .iWIdx(iWIdx), .iwReal(iwReal), .iwImg(iwImg),
`ifdef UBFLY_CONJ_EN
        .iConj(iConj),
`endif
        .iReal0(iReal0), .iImg0(iImg0), .iReal1(iReal1), .iImg1(iImg1),
        .oInReady(oInReady), .oValid(oValid), .oDone(oDone),
        .oReal0(oReal0), .oImg0(oImg0), .oReal1(oReal1), .oImg1(oImg1)
    );

    always #5 iClk = ~iClk;

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t", $time);
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    // Model state: twiddle codes as loaded (after saturation), per-lane frame data
    int         mw_r [NB];
    int         mw_i [NB];
    logic [3:0] dat [NB][L];    // {r0,i0,r1,i1}
    logic [3:0] cbits;
    int         ones [NB][4];   // 0:oReal0 1:oImg0 2:oReal1 3:oImg1
    int         done_n;

    typedef struct {
        bit                   do_load;
        int                   wr0, wi0, wr1, wi1;
        logic [3:0]           bits;
        int                   poke_at;
        logic [1:0][3:0][4:0] exp_ones;
    } vec_t;
    vec_t tbl [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Bipolar butterfly with unary twiddles: products are XNORs, the two low bits of k
    // pick which term reaches each output. Returns {oReal0,oImg0,oReal1,oImg1}.
    function automatic logic [3:0] model_lane(input int k, input int wr_code, input int wi_code,
                                              input bit conj, input logic [3:0] d);
        bit r0 = d[3];
        bit i0 = d[2];
        bit r1 = d[1];
        bit i1 = d[0];
        bit wr, wi, s1, s2, req, ieq;
        wr  = wr_code > k;
        wi  = (wi_code > k) ^ conj;
        s1  = (k % 2) == 1;
        s2  = ((k / 2) % 2) == 1;
        req = s1 ? (r1 == wr) : (i1 != wi);
        ieq = s1 ? (r1 == wi) : (i1 == wr);
        return s2 ? {r0, i0, r0, i0} : {req, ieq, !req, !ieq};
    endfunction

    function automatic logic [10:0] outs();
        return {oInReady, oValid, oDone, oReal0, oImg0, oReal1, oImg1};
    endfunction

    task automatic set_idle_inputs();
        iEn = 1'b1; iStart = 1'b0; iAbort = 1'b0; iWLoad = 1'b0;
        iWIdx = '0; iwReal = '0; iwImg = '0;
        iReal0 = '0; iImg0 = '0; iReal1 = '0; iImg1 = '0;
`ifdef UBFLY_CONJ_EN
        iConj = 1'b0;
`endif
    endtask

    task automatic load_tw(input int idx, input int wr, input int wi);
        @(negedge iClk);
        set_idle_inputs();
        iWLoad = 1'b1;
        iWIdx  = 1'(idx);
        iwReal = 5'(wr);
        iwImg  = 5'(wi);
        mw_r[idx] = (wr > L) ? L : wr;
        mw_i[idx] = (wi > L) ? L : wi;
        @(negedge iClk);
        set_idle_inputs();
    endtask

    // One frame driven from IDLE. ei counts enabled cycles since the start cycle (ei=0):
    // ready at 1..16 (sample k=ei-1), valid at 3..18 (result of k=ei-3), done at 19.
    // Stalled cycles show all-zero outputs; after an abort everything stays zero.
    task automatic run_frame(input bit rnd_bits, input bit rnd_en, input int stall_at,
                             input int stall_len, input int abort_at, input int poke_at,
                             input bit conj_val);
        int ei, n, stall_left;
        bit aborted, en_now, conj_eff;
        logic [3:0] d, m;
        logic [10:0] exp;
        logic [NB-1:0] er0, ei0, er1, ei1;
        conj_eff = conj_val & CONJ_EN;
        for (int k = 0; k < L; k++)
            for (int b = 0; b < NB; b++)
                dat[b][k] = rnd_bits ? 4'($urandom) : cbits;
        for (int b = 0; b < NB; b++)
            for (int o = 0; o < 4; o++) ones[b][o] = 0;
        ei = 0; n = 0; aborted = 1'b0; stall_left = stall_len; done_n = -1;
        while (ei <= 21 && n < 200) begin
            @(negedge iClk);
            en_now = 1'b1;
            if (ei > 0) begin
                if (ei == stall_at && stall_left > 0) begin
                    en_now = 1'b0;
                    stall_left--;
                end else if (rnd_en && $urandom_range(3, 0) == 0) begin
                    en_now = 1'b0;
                end
            end
            iRst   = 1'b0;
            iEn    = en_now;
            iStart = (ei == 0) || (ei == poke_at);
            iAbort = en_now && (ei == abort_at);
            iWLoad = (ei == poke_at);
            iWIdx  = '0;
            iwReal = 5'd3;
            iwImg  = 5'd11;
`ifdef UBFLY_CONJ_EN
            iConj  = (ei == 0) ? conj_val : 1'($urandom);
`endif
            for (int b = 0; b < NB; b++) begin
                d = (en_now && ei >= 1 && ei <= L) ? dat[b][ei-1] : 4'($urandom);
                iReal0[b] = d[3]; iImg0[b] = d[2]; iReal1[b] = d[1]; iImg1[b] = d[0];
            end
            #1;
            er0 = '0; ei0 = '0; er1 = '0; ei1 = '0;
            exp = '0;
            if (en_now && !aborted) begin
                if (ei >= 3 && ei <= L + 2) begin
                    for (int b = 0; b < NB; b++) begin
                        m = model_lane(ei - 3, mw_r[b], mw_i[b], conj_eff, dat[b][ei-3]);
                        er0[b] = m[3]; ei0[b] = m[2]; er1[b] = m[1]; ei1[b] = m[0];
                    end
                end
                exp = {(ei >= 1 && ei <= L), (ei >= 3 && ei <= L + 2), (ei == L + 3),
                       er0, ei0, er1, ei1};
            end
            check("frame_outputs", 32'(outs()), 32'(exp));
            if (oValid) begin
                for (int b = 0; b < NB; b++) begin
                    ones[b][0] += int'(oReal0[b]);
                    ones[b][1] += int'(oImg0[b]);
                    ones[b][2] += int'(oReal1[b]);
                    ones[b][3] += int'(oImg1[b]);
                end
            end
            if (oDone) done_n = n;
            if (en_now) begin
                if (ei == abort_at) aborted = 1'b1;
                ei++;
            end
            n++;
        end
        check("frame_complete", 32'(ei), 32'd22);
    endtask

    task automatic check_counts(input string name, input logic [1:0][3:0][4:0] e);
        for (int b = 0; b < NB; b++)
            for (int o = 0; o < 4; o++)
                check($sformatf("%s_lane%0d_out%0d", name, b, o), 32'(ones[b][o]), 32'(e[b][o]));
    endtask

    task automatic set_vec(input int i, input bit ld, input int wr0, input int wi0,
                           input int wr1, input int wi1, input logic [3:0] bits,
                           input int poke, input int a0, input int a1, input int a2,
                           input int a3, input int b0, input int b1, input int b2, input int b3);
        tbl[i].do_load = ld;
        tbl[i].wr0 = wr0; tbl[i].wi0 = wi0; tbl[i].wr1 = wr1; tbl[i].wi1 = wi1;
        tbl[i].bits = bits;
        tbl[i].poke_at = poke;
        tbl[i].exp_ones[0][0] = 5'(a0); tbl[i].exp_ones[0][1] = 5'(a1);
        tbl[i].exp_ones[0][2] = 5'(a2); tbl[i].exp_ones[0][3] = 5'(a3);
        tbl[i].exp_ones[1][0] = 5'(b0); tbl[i].exp_ones[1][1] = 5'(b1);
        tbl[i].exp_ones[1][2] = 5'(b2); tbl[i].exp_ones[1][3] = 5'(b3);
    endtask

    initial begin
        // bits = {r0,i0,r1,i1}; expected ones per lane: oReal0, oImg0, oReal1, oImg1
        set_vec(0, 0,  0,  0,  0, 0, 4'b0101, -1,  8, 12,  0, 12,   8, 12,  0, 12);
        set_vec(1, 1, 16,  0,  0, 0, 4'b1010,  4, 12,  0, 12,  8,   8,  4, 16,  4);
        set_vec(2, 1,  7, 10, 20, 3, 4'b0011, -1,  3,  5,  5,  3,   7,  5,  1,  3);
        set_vec(3, 1,  5, 13,  9, 2, 4'b1100, -1, 15, 11,  9, 13,  11, 12, 13, 12);
        for (int b = 0; b < NB; b++) begin mw_r[b] = 0; mw_i[b] = 0; end

        set_idle_inputs();
        iRst = 1'b1;
        repeat (2) @(negedge iClk);
        iRst = 1'b0;
        #1 check("reset_outputs", 32'(outs()), 32'd0);
        @(negedge iClk);
        #1 check("idle_outputs", 32'(outs()), 32'd0);

        // Table: reset/no-load frame, nominal frame with mid-RUN start+load poke, others
        for (int i = 0; i < 4; i++) begin
            if (tbl[i].do_load) begin
                load_tw(0, tbl[i].wr0, tbl[i].wi0);
                load_tw(1, tbl[i].wr1, tbl[i].wi1);
            end
            cbits = tbl[i].bits;
            run_frame(1'b0, 1'b0, -1, 0, -1, tbl[i].poke_at, 1'b0);
            check_counts($sformatf("vec%0d_ones", i), tbl[i].exp_ones);
            check($sformatf("vec%0d_done_cycle", i), 32'(done_n), 32'd19);
        end

        // Abort at k=5, then an identical fresh frame
        load_tw(0, tbl[1].wr0, tbl[1].wi0);
        load_tw(1, tbl[1].wr1, tbl[1].wi1);
        cbits = tbl[1].bits;
        run_frame(1'b0, 1'b0, -1, 0, 6, -1, 1'b0);
        check("abort_no_done", 32'(done_n), 32'hffffffff);
        run_frame(1'b0, 1'b0, -1, 0, -1, -1, 1'b0);
        check_counts("after_abort", tbl[1].exp_ones);

        // Stall for 3 cycles at k=7
        run_frame(1'b0, 1'b0, 8, 3, -1, -1, 1'b0);
        check_counts("stall", tbl[1].exp_ones);
        check("stall_done_cycle", 32'(done_n), 32'd22);

        // Reset in the middle of a frame clears twiddles
        @(negedge iClk);
        set_idle_inputs();
        iStart = 1'b1;
        repeat (8) begin
            @(negedge iClk);
            iStart = 1'b0;
        end
        iRst = 1'b1;
        @(negedge iClk);
        iRst = 1'b0;
        #1 check("reset_midframe", 32'(outs()), 32'd0);
        for (int b = 0; b < NB; b++) begin mw_r[b] = 0; mw_i[b] = 0; end
        cbits = tbl[0].bits;
        run_frame(1'b0, 1'b0, -1, 0, -1, -1, 1'b0);
        check_counts("after_reset", tbl[0].exp_ones);

        // Random twiddles, data and enable pattern against the model
        for (int f = 0; f < 8; f++) begin
            load_tw(0, int'($urandom_range(20, 0)), int'($urandom_range(20, 0)));
            load_tw(1, int'($urandom_range(20, 0)), int'($urandom_range(20, 0)));
            run_frame(1'b1, 1'b1, -1, 0, (f == 3) ? int'($urandom_range(18, 1)) : -1,
                      -1, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
